display_share_arbiter: RTL and testbench



---
 rtl/display_share_arbiter.sv | 131 +++++++++++++
 tb/tb_display_share_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/display_share_arbiter.sv
// Two-requester arbiter for the shared 8-digit seven-segment display: grants one side for a
// fixed hold time, snapshots its word onto HEX_out and round-robins on ties.
module display_share_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter logic [31:0] DEFAULT_HEX = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic [31:0] hex_a,
    input  logic        req_b,
    input  logic [31:0] hex_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        done_a,
    output logic        done_b,
    output logic [31:0] HEX_out,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShowA, StShowB} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hex_q, hex_d;
    logic               last_b_q, last_b_d;
    logic               done_a_q, done_a_d;
    logic               done_b_q, done_b_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic               busy_q, busy_d;
    logic               arb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hex_d    = hex_q;
        last_b_d = last_b_q;
        done_a_d = 1'b0;
        done_b_d = 1'b0;
        arb      = 1'b0;

        unique case (state_q)
            StIdle: arb = 1'b1;
            StShowA: begin
                // Expiry wins over a simultaneous drop of the request: the hold did complete.
                if (cnt_q == '0) begin
                    done_a_d = 1'b1;
                    last_b_d = 1'b0;
                    arb      = 1'b1;
                end else if (!req_a) begin
                    last_b_d = 1'b0;
                    arb      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StShowB: begin
                if (cnt_q == '0) begin
                    done_b_d = 1'b1;
                    last_b_d = 1'b1;
                    arb      = 1'b1;
                end else if (!req_b) begin
                    last_b_d = 1'b1;
                    arb      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: arb = 1'b1;
        endcase

        // Arbitration uses the freshly updated last-served side, so release/expiry hand off
        // in the same edge. HEX_out is left untouched when nobody is granted.
        if (arb) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (req_a && (!req_b || last_b_d)) begin
                state_d = StShowA;
                hex_d   = hex_a;
                cnt_d   = HoldLoad;
            end else if (req_b) begin
                state_d = StShowB;
                hex_d   = hex_b;
                cnt_d   = HoldLoad;
            end
        end

        gnt_a_d = (state_d == StShowA);
        gnt_b_d = (state_d == StShowB);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hex_q    <= DEFAULT_HEX;
            last_b_q <= 1'b1;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hex_q    <= hex_d;
            last_b_q <= last_b_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign done_a  = done_a_q;
    assign done_b  = done_b_q;
    assign HEX_out = hex_q;
    assign busy    = busy_q;

    gnt_onehot_a: assert property (@(posedge clock) disable iff (!reset) !(gnt_a && gnt_b));
    done_onehot_a: assert property (@(posedge clock) disable iff (!reset) !(done_a && done_b));

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter: directed vector table, async reset corner
// cases and a randomized run against a cycle-level ownership model.
module tb_display_share_arbiter;

    localparam int unsigned HOLD = 4;
    localparam logic [31:0] H1 = 32'h1234_5678;
    localparam logic [31:0] H2 = 32'h8765_4321;
    localparam logic [31:0] HB = 32'hABCD_EF01;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] hex_a = '0, hex_b = '0;
    logic        gnt_a, gnt_b, done_a, done_b, busy;
    logic [31:0] HEX_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    display_share_arbiter #(
        .HOLD_CYCLES(HOLD),
        .DEFAULT_HEX(32'h0000_0000)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req_a  (req_a),
        .hex_a  (hex_a),
        .req_b  (req_b),
        .hex_b  (hex_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b),
        .done_a (done_a),
        .done_b (done_b),
        .HEX_out(HEX_out),
        .busy   (busy)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic        ra;
        logic [31:0] ha;
        logic        rb;
        logic [31:0] hb;
        logic        ga, gb, da, db;
        logic [31:0] hex;
    } vec_t;

    function automatic vec_t mk(input logic ra, input logic [31:0] ha, input logic rb,
                                input logic [31:0] hb, input logic ga, input logic gb,
                                input logic da, input logic db, input logic [31:0] hex);
        vec_t v;
        v.ra = ra; v.ha = ha; v.rb = rb; v.hb = hb;
        v.ga = ga; v.gb = gb; v.da = da; v.db = db; v.hex = hex;
        return v;
    endfunction

    // exp = {gnt_a, gnt_b, done_a, done_b, busy, HEX_out}
    task automatic check(input string name, input logic [36:0] exp);
        logic [36:0] got;
        got = {gnt_a, gnt_b, done_a, done_b, busy, HEX_out};
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got gnt_a=%b gnt_b=%b done_a=%b done_b=%b busy=%b hex=%h, expected gnt_a=%b gnt_b=%b done_a=%b done_b=%b busy=%b hex=%h",
                     name, got[36], got[35], got[34], got[33], got[32], got[31:0],
                     exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    // Reference model: who owns the display, for how many cycles, and who was served last.
    int          m_owner;  // 0 none, 1 A, 2 B
    int          m_age;
    int          m_last;
    logic [31:0] m_hex;
    logic        m_da, m_db;

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_last = 2; m_hex = '0; m_da = 0; m_db = 0;
    endtask

    task automatic model_step(input logic ra, input logic rb, input logic [31:0] ha,
                              input logic [31:0] hb);
        bit free;
        int pick;
        free = 0; m_da = 0; m_db = 0;
        if (m_owner == 0) begin
            free = 1;
        end else if (m_age == HOLD) begin
            if (m_owner == 1) m_da = 1; else m_db = 1;
            m_last = m_owner;
            free = 1;
        end else if ((m_owner == 1 && !ra) || (m_owner == 2 && !rb)) begin
            m_last = m_owner;
            free = 1;
        end else begin
            m_age++;
        end
        if (free) begin
            if (ra && rb) pick = (m_last == 1) ? 2 : 1;
            else if (ra)  pick = 1;
            else if (rb)  pick = 2;
            else          pick = 0;
            m_owner = pick;
            if (pick != 0) begin
                m_age = 1;
                m_hex = (pick == 1) ? ha : hb;
            end
        end
    endtask

    function automatic logic [36:0] model_exp();
        return {m_owner == 1, m_owner == 2, m_da, m_db, m_owner != 0, m_hex};
    endfunction

    vec_t tbl[19];

    initial begin
        tbl[0]  = mk(1, H1, 1, HB, 1, 0, 0, 0, H1);  // tie from idle: A first
        tbl[1]  = mk(1, H2, 1, HB, 1, 0, 0, 0, H1);  // hex_a change ignored
        tbl[2]  = mk(1, H2, 1, HB, 1, 0, 0, 0, H1);
        tbl[3]  = mk(1, H2, 1, HB, 1, 0, 0, 0, H1);
        tbl[4]  = mk(1, H2, 1, HB, 0, 1, 1, 0, HB);  // expiry, handoff to B
        tbl[5]  = mk(1, H2, 1, HB, 0, 1, 0, 0, HB);
        tbl[6]  = mk(1, H2, 1, HB, 0, 1, 0, 0, HB);
        tbl[7]  = mk(1, H2, 1, HB, 0, 1, 0, 0, HB);
        tbl[8]  = mk(1, H2, 1, HB, 1, 0, 0, 1, H2);  // back to A, new snapshot
        tbl[9]  = mk(1, H1, 0, HB, 1, 0, 0, 0, H2);
        tbl[10] = mk(1, H1, 0, HB, 1, 0, 0, 0, H2);
        tbl[11] = mk(1, H1, 0, HB, 1, 0, 0, 0, H2);
        tbl[12] = mk(1, H1, 0, HB, 1, 0, 1, 0, H1);  // sole requester re-granted
        tbl[13] = mk(1, H1, 0, HB, 1, 0, 0, 0, H1);
        tbl[14] = mk(0, H1, 1, HB, 0, 1, 0, 0, HB);  // A releases early, B same edge
        tbl[15] = mk(0, H1, 1, HB, 0, 1, 0, 0, HB);
        tbl[16] = mk(0, H1, 0, HB, 0, 0, 0, 0, HB);  // B releases early, display keeps word
        tbl[17] = mk(1, H1, 0, HB, 1, 0, 0, 0, H1);
        tbl[18] = mk(1, H1, 0, HB, 1, 0, 0, 0, H1);

        // Reset and idle persistence
        #5;
        check("reset_during", 37'd0);
        #10 reset = 1'b1;
        @(negedge clock);
        check("reset_released", 37'd0);
        @(negedge clock);
        check("idle_no_req", 37'd0);

        for (int i = 0; i < 19; i++) begin
            req_a = tbl[i].ra; hex_a = tbl[i].ha;
            req_b = tbl[i].rb; hex_b = tbl[i].hb;
            @(negedge clock);
            check($sformatf("table[%0d]", i),
                  {tbl[i].ga, tbl[i].gb, tbl[i].da, tbl[i].db, tbl[i].ga | tbl[i].gb, tbl[i].hex});
        end

        // Asynchronous reset while A holds the display
        #3 reset = 1'b0;
        #2 check("async_reset_mid_hold", 37'd0);
        req_a = 1'b1; hex_a = H2; req_b = 1'b1; hex_b = HB;
        #2 reset = 1'b1;
        @(negedge clock);
        check("post_reset_tie_a", {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, H2});
        @(negedge clock);
        check("post_reset_hold", {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, H2});

        // Randomized run against the model
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            req_a = ($urandom_range(0, 7) != 0);
            req_b = ($urandom_range(0, 3) != 0);
            hex_a = $urandom;
            hex_b = $urandom;
            model_step(req_a, req_b, hex_a, hex_b);
            @(negedge clock);
            check($sformatf("random[%0d]", i), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
